// File: rtl/pipe_ctl_pkg.sv
// pipe_ctl_pkg: WB control-word layout and datapath widths shared by WB and the register file.
package pipe_ctl_pkg;
    localparam int CTL_W     = 17;
    localparam int CTL_RF_EN = 9;
    localparam int CTL_HI_EN = 2;
    localparam int CTL_LO_EN = 1;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
endpackage

// File: rtl/regfile_hilo_sb_counter.sv
// sb_counter: saturating up/down pending-write counter; err pulses on overflow or underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up, dn, full, empty;

    always_comb begin
        up    = inc & ~dec;
        dn    = dec & ~inc;
        full  = &cnt_q;
        empty = ~|cnt_q;
        cnt_d = reset ? '0 :
                (up && !full) ? cnt_q + 1'b1 :
                (dn && !empty) ? cnt_q - 1'b1 : cnt_q;
        err   = ~reset & ((up & full) | (dn & empty));
    end

    always_ff @(posedge clk) cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/regfile_hilo_sb.sv
// regfile_hilo_sb: 32x32 GPR file with HI/LO, WB-to-ID bypass and a per-register pending-write scoreboard.
module regfile_hilo_sb
    import pipe_ctl_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CTL_W-1:0] wb_ctl,
    input  logic [AW-1:0]    wb_rd,
    input  logic [DW-1:0]    wb_data,
    input  logic [DW-1:0]    wb_hi_data,
    input  logic [DW-1:0]    wb_lo_data,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_issue,
    input  logic [AW-1:0]    id_issue_rd,
    output logic [DW-1:0]    rs_data,
    output logic [DW-1:0]    rt_data,
    output logic [DW-1:0]    hi_data,
    output logic [DW-1:0]    lo_data,
    output logic             rs_pending,
    output logic             rt_pending,
    output logic             sb_err
);
    localparam int NREG = 1 << AW;

    logic [DW-1:0]    gpr_q [NREG];
    logic [DW-1:0]    gpr_d [NREG];
    logic [DW-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic             sb_err_q, sb_err_d;
    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  inc_v, dec_v, err_v;
    logic             rf_we, hi_we, lo_we, iss;

    // Bypass and retire are both gated by reset so stored state is what shows while in reset.
    always_comb begin
        rf_we = ~reset & wb_ctl[CTL_RF_EN] & (wb_rd != '0);
        hi_we = ~reset & wb_ctl[CTL_HI_EN];
        lo_we = ~reset & wb_ctl[CTL_LO_EN];
        iss   = ~reset & id_issue & (id_issue_rd != '0);
        gpr_d[0] = '0;
        for (int i = 1; i < NREG; i++)
            gpr_d[i] = reset ? '0 : (rf_we && wb_rd == AW'(i)) ? wb_data : gpr_q[i];
        hi_d = reset ? '0 : hi_we ? wb_hi_data : hi_q;
        lo_d = reset ? '0 : lo_we ? wb_lo_data : lo_q;
        inc_v = iss ? NREG'(1) << id_issue_rd : '0;
        dec_v = rf_we ? NREG'(1) << wb_rd : '0;
        sb_err_d = reset ? 1'b0 : sb_err_q | (|err_v);
    end

    always_ff @(posedge clk) begin
        gpr_q    <= gpr_d;
        hi_q     <= hi_d;
        lo_q     <= lo_d;
        sb_err_q <= sb_err_d;
    end

    assign cnt[0]   = '0;
    assign err_v[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_sb
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_v[g]),
            .dec   (dec_v[g]),
            .cnt   (cnt[g]),
            .err   (err_v[g])
        );
    end

    // A register whose last outstanding write retires this cycle is satisfied by the bypass.
    always_comb begin
        rs_data    = (id_rs == '0) ? '0 : (rf_we && wb_rd == id_rs) ? wb_data : gpr_q[id_rs];
        rt_data    = (id_rt == '0) ? '0 : (rf_we && wb_rd == id_rt) ? wb_data : gpr_q[id_rt];
        hi_data    = hi_we ? wb_hi_data : hi_q;
        lo_data    = lo_we ? wb_lo_data : lo_q;
        rs_pending = (id_rs != '0) && (cnt[id_rs] != '0) &&
                     !(rf_we && wb_rd == id_rs && cnt[id_rs] == CNT_W'(1));
        rt_pending = (id_rt != '0) && (cnt[id_rt] != '0) &&
                     !(rf_we && wb_rd == id_rt && cnt[id_rt] == CNT_W'(1));
        sb_err     = sb_err_q;
    end
endmodule

// File: tb/tb_regfile_hilo_sb.sv
// tb_regfile_hilo_sb: directed checks of writes, bypass, HI/LO, scoreboard and reset.
module tb_regfile_hilo_sb;
    import pipe_ctl_pkg::*;

    localparam logic [CTL_W-1:0] RF = 1 << CTL_RF_EN;
    localparam logic [CTL_W-1:0] HI = 1 << CTL_HI_EN;
    localparam logic [CTL_W-1:0] LO = 1 << CTL_LO_EN;

    logic             clk = 0, reset;
    logic [CTL_W-1:0] wb_ctl;
    logic [4:0]       wb_rd, id_rs, id_rt, id_issue_rd;
    logic [31:0]      wb_data, wb_hi_data, wb_lo_data;
    logic             id_issue;
    logic [31:0]      rs_data, rt_data, hi_data, lo_data;
    logic             rs_pending, rt_pending, sb_err;
    int               errors = 0, checks = 0;

    regfile_hilo_sb dut (
        .clk(clk), .reset(reset), .wb_ctl(wb_ctl), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data), .id_rs(id_rs), .id_rt(id_rt),
        .id_issue(id_issue), .id_issue_rd(id_issue_rd), .rs_data(rs_data), .rt_data(rt_data),
        .hi_data(hi_data), .lo_data(lo_data), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [CTL_W-1:0] c, input logic [4:0] rd, input logic [31:0] d);
        wb_ctl = c; wb_rd = rd; wb_data = d;
    endtask

    task automatic issue(input logic en, input logic [4:0] rd);
        id_issue = en; id_issue_rd = rd;
    endtask

    initial begin
        reset = 1; wb(RF, 5, 32'hDEADBEEF); wb_hi_data = 0; wb_lo_data = 0;
        id_rs = 5; id_rt = 0; issue(0, 0);
        tick();
        #1 chk("rst_rs_hold", rs_data, 0);
        tick();
        reset = 0; wb(0, 0, 0);
        #1 chk("rst_rs", rs_data, 0);
        chk("rst_rs_pend", rs_pending, 0);
        chk("rst_err", sb_err, 0);
        chk("rst_hi", hi_data, 0);
        chk("rst_lo", lo_data, 0);

        issue(1, 7); tick();
        issue(0, 0); wb(RF, 7, 32'h12345678); tick();
        wb(0, 0, 0); id_rs = 7;
        #1 chk("r7_read", rs_data, 32'h12345678);
        chk("r7_pend", rs_pending, 0);
        wb(RF, 0, 32'hFFFFFFFF); id_rt = 0;
        #1 chk("r0_same", rt_data, 0);
        tick(); wb(0, 0, 0);
        #1 chk("r0_after", rt_data, 0);

        issue(1, 3); tick();
        issue(0, 0); wb(RF, 3, 32'hA5A5A5A5); id_rs = 3; id_rt = 3;
        #1 chk("byp_rs", rs_data, 32'hA5A5A5A5);
        chk("byp_rt", rt_data, 32'hA5A5A5A5);
        chk("byp_pend", rs_pending, 0);
        tick(); wb(HI | LO, 0, 0); wb_hi_data = 32'h1; wb_lo_data = 32'h2;
        #1 chk("hi_byp", hi_data, 32'h1);
        chk("lo_byp", lo_data, 32'h2);
        tick(); wb(0, 0, 0); wb_hi_data = 32'h77; wb_lo_data = 32'h88;
        #1 chk("hi_keep", hi_data, 32'h1);
        chk("lo_keep", lo_data, 32'h2);
        chk("r3_stored", rs_data, 32'hA5A5A5A5);
        chk("err_clean", sb_err, 0);

        issue(1, 9); tick(); tick();
        issue(0, 0); id_rs = 9;
        #1 chk("r9_pend2", rs_pending, 1);
        wb(RF, 9, 32'h99);
        #1 chk("r9_ret1_pend", rs_pending, 1);
        chk("r9_ret1_data", rs_data, 32'h99);
        tick(); wb(RF, 9, 32'h9A);
        #1 chk("r9_ret2_pend", rs_pending, 0);
        chk("r9_ret2_data", rs_data, 32'h9A);
        tick(); wb(0, 0, 0);
        #1 chk("r9_done", rs_pending, 0);
        chk("r9_stored", rs_data, 32'h9A);

        issue(1, 4); tick();
        wb(RF, 4, 32'h44); id_rs = 4;
        #1 chk("r4_same_pend", rs_pending, 0);
        tick(); issue(0, 0); wb(0, 0, 0);
        #1 chk("r4_still1", rs_pending, 1);
        wb(RF, 4, 32'h45); tick(); wb(0, 0, 0);
        #1 chk("r4_clear", rs_pending, 0);
        chk("err_clean2", sb_err, 0);

        issue(1, 6); tick(); tick(); tick();
        chk("r6_3iss_err", sb_err, 0);
        tick(); issue(0, 0); id_rs = 6;
        #1 chk("r6_ovf_err", sb_err, 1);
        chk("r6_pend", rs_pending, 1);
        wb(RF, 6, 32'h61); tick();
        wb(RF, 6, 32'h62);
        #1 chk("r6_cnt2_pend", rs_pending, 1);
        tick(); wb(RF, 6, 32'h63);
        #1 chk("r6_cnt1_pend", rs_pending, 0);
        tick(); wb(0, 0, 0);
        #1 chk("r6_empty", rs_pending, 0);
        chk("r6_data", rs_data, 32'h63);

        id_rs = 8; wb(RF, 8, 32'h80);
        #1 chk("r8_udf_pend", rs_pending, 0);
        tick(); wb(0, 0, 0);
        #1 chk("r8_udf_err", sb_err, 1);
        chk("r8_cnt0", rs_pending, 0);
        issue(1, 8); tick(); issue(0, 0);
        #1 chk("r8_cnt1", rs_pending, 1);
        wb(RF, 8, 32'h81);
        #1 chk("r8_ret_pend", rs_pending, 0);
        tick(); wb(0, 0, 0);
        #1 chk("r8_sticky", sb_err, 1);

        issue(1, 10); wb(HI, 0, 0); wb_hi_data = 32'h55; tick();
        wb(0, 0, 0); tick(); issue(0, 0); id_rt = 10;
        #1 chk("r10_pend", rt_pending, 1);
        chk("hi55", hi_data, 32'h55);
        reset = 1; wb(HI, 0, 0); wb_hi_data = 32'h66;
        #1 chk("rst_hi_nobyp", hi_data, 32'h55);
        tick(); reset = 0; wb(0, 0, 0); id_rs = 7;
        #1 chk("mid_rst_pend", rt_pending, 0);
        chk("mid_rst_hi", hi_data, 0);
        chk("mid_rst_err", sb_err, 0);
        chk("mid_rst_r7", rs_data, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
